fifo: RTL and testbench

- Synchronous single-clock FIFO buffer with full status/handshake flag set.
- Sits between a producer (write side) and a consumer (read side).
- Storage is DEPTH x WIDTH register array with read/write pointers and an occupancy counter.
- Reports per-cycle write/read acknowledges, overflow/underflow errors, and level flags.

---
 rtl/fifo.sv | 101 ++++++++++
 tb/tb_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock FIFO: DEPTH x WIDTH register array, wrapping pointers and an
// occupancy counter, with registered ack/error pulses and combinational level flags.
module fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a request (wr_en / rd_en) sampled on a rising edge is either
  // accepted (wr_ack / rd_ack high the next cycle) or rejected (overflow /
  // underflow high the next cycle); read data appears with rd_ack.
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, rd_ack_q, ovf_q, unf_q;
  logic                  wr_fire, rd_fire;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q == CW'(FIFO_DEPTH - 1));
  assign almostempty = (count_q == CW'(1));

  // On full a simultaneous read still proceeds, so the write is judged on the
  // pre-edge count; likewise on empty only the write proceeds.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_fire) wr_ptr_d = inc_ptr(wr_ptr_q);
    if (rd_fire) begin
      rd_ptr_d = inc_ptr(rd_ptr_q);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_fire;
      rd_ack_q <= rd_fire;
      ovf_q    <= wr_en && !wr_fire;
      unf_q    <= rd_en && !rd_fire;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out  = dout_q;
  assign wr_ack    = wr_ack_q;
  assign rd_ack    = rd_ack_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo.sv
// Testbench for fifo: directed and random traffic against a queue-based
// reference model; a monitor compares pulses, flags and read data every cycle.
module tb_fifo;
  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         wr_en, rd_en;
  logic [W-1:0] data_out;
  logic         wr_ack, rd_ack, overflow, underflow;
  logic         full, empty, almostfull, almostempty;

  fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .data_out(data_out), .wr_ack(wr_ack), .rd_ack(rd_ack),
    .overflow(overflow), .underflow(underflow), .full(full), .empty(empty),
    .almostfull(almostfull), .almostempty(almostempty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         wr_ack, rd_ack, ovf, unf;
    logic         full, empty, af, ae;
    logic [W-1:0] dout;
  } exp_t;

  exp_t         flag_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q[$];
  logic [W-1:0] last_dout;
  int           n_cmp = 0;
  int           n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // One cycle of stimulus; the model decides what the DUT must show after the next edge.
  task automatic drive(input logic w, input logic r, input logic [W-1:0] d);
    exp_t e;
    int   cnt;
    logic w_ok, r_ok;
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d;
    cnt  = model_q.size();
    w_ok = w && (cnt < D);
    r_ok = r && (cnt > 0);
    if (r_ok) begin
      last_dout = model_q.pop_front();
      exp_q.push_back(last_dout);
    end
    if (w_ok) model_q.push_back(d);
    cnt      = model_q.size();
    e.wr_ack = w_ok;
    e.rd_ack = r_ok;
    e.ovf    = w && !w_ok;
    e.unf    = r && !r_ok;
    e.full   = (cnt == D);
    e.empty  = (cnt == 0);
    e.af     = (cnt == D - 1);
    e.ae     = (cnt == 1);
    e.dout   = last_dout;
    flag_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " empty"}, 32'(empty), 32'd1);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " af/ae"}, 32'({almostfull, almostempty}), 32'd0);
    chk({tag, " data_out"}, 32'(data_out), 32'd0);
    chk({tag, " pulses"}, 32'({wr_ack, rd_ack, overflow, underflow}), 32'd0);
  endtask

  // Monitor: one expectation per driven cycle, read data popped on rd_ack.
  initial begin
    exp_t e;
    logic [W-1:0] want;
    forever begin
      @(posedge clk);
      #1;
      if (flag_q.size() > 0) begin
        e = flag_q.pop_front();
        chk("wr_ack", 32'(wr_ack), 32'(e.wr_ack));
        chk("rd_ack", 32'(rd_ack), 32'(e.rd_ack));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("underflow", 32'(underflow), 32'(e.unf));
        chk("full", 32'(full), 32'(e.full));
        chk("empty", 32'(empty), 32'(e.empty));
        chk("almostfull", 32'(almostfull), 32'(e.af));
        chk("almostempty", 32'(almostempty), 32'(e.ae));
        chk("data_out_hold", 32'(data_out), 32'(e.dout));
        if (rd_ack) begin
          if (exp_q.size() == 0) begin
            chk("rd_ack_unexpected", 32'd1, 32'd0);
          end else begin
            want = exp_q.pop_front();
            chk("read_data", 32'(data_out), 32'(want));
          end
        end
      end
    end
  end

  initial begin
    int wprob, rprob;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; last_dout = '0;
    #1;
    chk_reset_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("idle");

    // Fill to full, then one rejected write.
    for (int i = 1; i <= D; i++) drive(1'b1, 1'b0, W'(i));
    drive(1'b1, 1'b0, 8'hAA);
    // Drain, then one rejected read (data_out must hold 0x10).
    for (int i = 0; i < D; i++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    idle();

    // Simultaneous on empty, on full, and with 5 entries.
    drive(1'b1, 1'b1, 8'h55);
    drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < D; i++) drive(1'b1, 1'b0, W'(8'h20 + i));
    drive(1'b1, 1'b1, 8'hBB);
    while (model_q.size() > 5) drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h66);
    drive(1'b1, 1'b1, 8'h67);
    while (model_q.size() > 0) drive(1'b0, 1'b1, 8'h00);

    // Wrap-around: 10 in/out, then 12 in/out.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, W'(8'h40 + i));
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, W'(8'h80 + i));
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 8'h00);

    // Asynchronous reset between edges with 7 entries.
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, W'(8'hC0 + i));
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("async_reset");
    model_q.delete();
    exp_q.delete();
    last_dout = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'h00);

    // Random traffic with shifting write/read bias.
    for (int blk = 0; blk < 20; blk++) begin
      wprob = $urandom_range(10, 90);
      rprob = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++)
        drive(($urandom_range(0, 99) < wprob), ($urandom_range(0, 99) < rprob),
              W'($urandom));
    end

    idle();
    repeat (3) @(negedge clk);
    chk("leftover_expectations", 32'(flag_q.size() + exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
